// File: rtl/sn_output_arbiter_pkg.sv
// sn_output_arbiter_pkg
//   Shared SiliconNet switch types used by the per-output arbiter:
//   port index type, raise/credit/grant structs, arbiter state enum,
//   credit width and a round-robin pointer helper.
//   Optional feature macro used by the arbiter: SN_ARB_MSG_LOCK_EN.
package sn_output_arbiter_pkg;

  localparam int SN_NUM_PORTS                 = 8;
  localparam int SN_FLITS_PER_PORT_DOWNSTREAM = 32;
  localparam int SN_PORT_W                    = $clog2(SN_NUM_PORTS);
  localparam int SN_ARB_CREDIT_WIDTH          = $clog2(SN_FLITS_PER_PORT_DOWNSTREAM + 1);

  typedef logic [SN_PORT_W-1:0] Port;

  typedef struct packed {
    logic                    valid;
    logic [SN_NUM_PORTS-1:0] dst_port_one_hot;
    logic                    last;
    logic                    msg_last;
  } SwitchRaise;

  typedef struct packed {
    logic valid;
    Port  port;
  } SwitchCredit;

  typedef struct packed {
    logic valid;
    Port  src_port;
    Port  dst_port;
  } SwitchGrant;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    LOCKED = 2'd2
  } SN_ARB_STATE;

  // Port after p, wrapping at SN_NUM_PORTS (which need not be a power of two).
  function automatic Port sn_next_port(input Port p);
    if (int'(p) == SN_NUM_PORTS - 1) return '0;
    return Port'(int'(p) + 1);
  endfunction

endpackage

// File: rtl/sn_output_arbiter_rr_picker.sv
// sn_rr_picker
//   Combinational round-robin picker: rotate the request vector so the
//   pointer position is bit 0, take the lowest set bit, then rotate the
//   index back.
//   Ports:
//     req_i    - one request bit per source port
//     ptr_i    - highest-priority port this round
//     any_o    - at least one request is set
//     winner_o - selected port (valid only when any_o)
module sn_rr_picker
  import sn_output_arbiter_pkg::*;
#(
  parameter int N  = SN_NUM_PORTS,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic          any_o,
  output logic [PW-1:0] winner_o
);

  logic [N-1:0]  rot;
  logic [PW-1:0] idx;

  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req_i[PW'((i + int'(ptr_i)) % N)];
    end
    any_o = |rot;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) idx = PW'(i);
    end
    winner_o = PW'((int'(idx) + int'(ptr_i)) % N);
  end

endmodule

// File: rtl/sn_output_arbiter.sv
// sn_output_arbiter
//   Per-output-port arbiter for the SiliconSwitch crossbar. Round-robin
//   arbitration at packet boundaries, gated by downstream flit credits;
//   a granted packet owns the port until its last phit. The grant is
//   combinational from registered state and the current raises.
//   Optional feature: define SN_ARB_MSG_LOCK_EN to keep a multi-packet
//   message on the port until its msg_last phit (no interleaving).
//   Ports:
//     clk, rst      - switch clock, synchronous active-high reset
//     raise_in      - one SwitchRaise per source port
//     credit_in     - downstream credit return
//     grant_out     - grant for this output port (drives the mux select)
//     busy          - state is not IDLE (registered)
//     owner         - current port holder, meaningful while busy
//     credit_count  - credits currently available
//     credit_err    - sticky: credit returned while already full
//
//   state  | meaning
//   -------+---------------------------------------------------
//   IDLE   | no owner; arbitrate among targeting raises
//   BUSY   | owner's packet mid-transfer; only owner is granted
//   LOCKED | between packets of owner's message (macro only)
module sn_output_arbiter
  import sn_output_arbiter_pkg::*;
#(
  parameter int OUT_PORT     = 0,
  parameter int INIT_CREDITS = SN_FLITS_PER_PORT_DOWNSTREAM,
  parameter int CREDIT_W     = $clog2(INIT_CREDITS + 1)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  SwitchRaise [SN_NUM_PORTS-1:0]     raise_in,
  input  SwitchCredit                       credit_in,
  output SwitchGrant                        grant_out,
  output logic                              busy,
  output Port                               owner,
  output logic [CREDIT_W-1:0]               credit_count,
  output logic                              credit_err
);

  localparam logic [CREDIT_W-1:0] INIT_C = CREDIT_W'(INIT_CREDITS);

  SN_ARB_STATE           state_q, state_d;
  Port                   owner_q, owner_d;
  Port                   rr_ptr_q, rr_ptr_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic                  busy_q;
  logic                  credit_err_q;

  logic [SN_NUM_PORTS-1:0] req;
  logic                    pick_any;
  Port                     pick_w;
  logic                    grant_v;
  Port                     grant_src;
  logic                    start;
  logic                    ret;
  logic                    credit_full;
  logic                    credit_ok;
  SwitchRaise              cur;

  // Only the one-hot bit for this port is decoded; the rest are deliberately ignored.
  logic unused_raise;
  assign unused_raise = ^raise_in;

  always_comb begin
    req = '0;
    for (int i = 0; i < SN_NUM_PORTS; i++) begin
      req[i] = raise_in[i].valid & raise_in[i].dst_port_one_hot[OUT_PORT];
    end
  end

  sn_rr_picker #(
    .N  (SN_NUM_PORTS),
    .PW (SN_PORT_W)
  ) u_picker (
    .req_i    (req),
    .ptr_i    (rr_ptr_q),
    .any_o    (pick_any),
    .winner_o (pick_w)
  );

  assign cur         = raise_in[owner_q];
  assign credit_ok   = (credit_q != '0);
  assign credit_full = (credit_q == INIT_C);
  assign ret         = credit_in.valid && (credit_in.port == Port'(OUT_PORT));

  always_comb begin
    grant_v   = 1'b0;
    grant_src = owner_q;
    start     = 1'b0;
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (credit_ok && pick_any) begin
          grant_v   = 1'b1;
          grant_src = pick_w;
          start     = 1'b1;
          owner_d   = pick_w;
          rr_ptr_d  = sn_next_port(pick_w);
          if (!raise_in[pick_w].last) begin
            state_d = BUSY;
          end
`ifdef SN_ARB_MSG_LOCK_EN
          else if (!raise_in[pick_w].msg_last) begin
            state_d = LOCKED;
          end
`endif
        end
      end
      BUSY: begin
        // Credit for the whole packet was taken at its first phit.
        if (req[owner_q]) begin
          grant_v = 1'b1;
          if (cur.last) begin
            state_d = IDLE;
`ifdef SN_ARB_MSG_LOCK_EN
            if (!cur.msg_last) state_d = LOCKED;
`endif
          end
        end
      end
`ifdef SN_ARB_MSG_LOCK_EN
      LOCKED: begin
        // Packet starts inside a message leave the round-robin pointer alone.
        if (credit_ok && req[owner_q]) begin
          grant_v = 1'b1;
          start   = 1'b1;
          if (!cur.last) begin
            state_d = BUSY;
          end else if (cur.msg_last) begin
            state_d = IDLE;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Consume and return in the same cycle cancel; a return when full saturates.
  always_comb begin
    credit_d = credit_q;
    case ({start, ret})
      2'b10:   credit_d = credit_q - CREDIT_W'(1);
      2'b01:   credit_d = credit_full ? credit_q : credit_q + CREDIT_W'(1);
      default: credit_d = credit_q;
    endcase
  end

  always_comb begin
    grant_out = '0;
    if (!rst) begin
      grant_out.valid    = grant_v;
      grant_out.src_port = grant_v ? grant_src : Port'(0);
      grant_out.dst_port = Port'(OUT_PORT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      credit_q     <= INIT_C;
      busy_q       <= 1'b0;
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      credit_q     <= credit_d;
      busy_q       <= (state_d != IDLE);
      credit_err_q <= credit_err_q | (ret & credit_full);
    end
  end

  assign busy         = busy_q;
  assign owner        = owner_q;
  assign credit_count = credit_q;
  assign credit_err   = credit_err_q;

endmodule
